gate_share_arbiter: RTL and testbench

GATE_SHARE_ARBITER -- requirements
Module: gate_share_arbiter

---
 rtl/gate_share_pkg.sv | 24 ++
 rtl/rr_pick.sv | 38 +++
 rtl/gate_share_arbiter.sv | 124 ++++++++++++
 tb/tb_gate_share_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_share_pkg.sv
// Shared definitions for the gate-share arbiter: FSM encodings and a
// constant-evaluable ceiling-log2 used to size pointers and counters.
package gate_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a vector sized by it is always legal.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import gate_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);

  logic          found;
  int            pos;
  logic [IW-1:0] k;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      k = IW'(pos);
      if (!found && req[k]) begin
        found  = 1'b1;
        win[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/gate_share_arbiter.sv
// Time-shares one functional unit among NREQ requesters. An owner keeps the
// unit until it strobes last, drops its request, or overstays HOLD_MAX
// cycles; every ownership is followed by a single dead GAP cycle.
//
// state | meaning
// IDLE  | no owner; arbitrate on any request, grant lands on the next edge
// OWN   | one requester owns the unit, hold counter running
// GAP   | one dead cycle after release before the next arbitration
module gate_share_arbiter
  import gate_share_pkg::*;
#(
  parameter int WD       = 4,
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*WD-1:0] op_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [WD-1:0]      fu_in,
  output logic               fu_valid,
  output logic               timeout
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(HOLD_MAX + 1);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   hold_cnt;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            rel_last;
  logic            rel_drop;
  logic            expire;
  logic [IW-1:0]   next_ptr;
  logic [WD-1:0]   slice [NREQ];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx)
  );

  // Unpack the operand bus so the owner can index it directly.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      slice[k] = op_data[k*WD +: WD];
    end
  end

  // Release conditions for the current owner; last from others is never looked at.
  always_comb begin
    rel_last = last[owner];
    rel_drop = !req[owner];
    expire   = (hold_cnt == CW'(HOLD_MAX));
    next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  end

  // Operand routing follows the live request of the owner, zero outside OWN.
  always_comb begin
    fu_in    = '0;
    fu_valid = 1'b0;
    if (state == OWN) begin
      fu_in    = slice[owner];
      fu_valid = req[owner];
    end
  end

  // Ownership FSM with registered grant, busy and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= OWN;
            owner    <= pick_idx;
            gnt      <= pick_win;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          hold_cnt <= hold_cnt + CW'(1);
          if (rel_last || rel_drop || expire) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= next_ptr;
            // A voluntary release in the expiry cycle is not a forced one.
            timeout <= expire && !rel_last && !rel_drop;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Self-checking bench for gate_share_arbiter with default parameters.
module tb_gate_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [15:0] op_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  fu_in;
  logic        fu_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  exp_gnt;
    int          exp_idx;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] fu;
  } exp_t;

  vec_t tbl [9];
  exp_t sb [$];

  gate_share_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .last     (last),
    .op_data  (op_data),
    .gnt      (gnt),
    .busy     (busy),
    .fu_in    (fu_in),
    .fu_valid (fu_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [15:0] d;
    logic [3:0]  prev;
    int          n, owned, zeros, grants;

    // Hand-computed round-robin expectations, ptr starting at 0 after reset.
    tbl[0] = '{4'b0001, 16'h0, 4'b0001, 0};  // ptr -> 1
    tbl[1] = '{4'b0001, 16'h0, 4'b0001, 0};  // wraps from 1, ptr -> 1
    tbl[2] = '{4'b1001, 16'h0, 4'b1000, 3};  // ptr -> 0
    tbl[3] = '{4'b0110, 16'h0, 4'b0010, 1};  // ptr -> 2
    tbl[4] = '{4'b0011, 16'h0, 4'b0001, 0};  // wraps, ptr -> 1
    tbl[5] = '{4'b1111, 16'h0, 4'b0010, 1};  // ptr -> 2
    tbl[6] = '{4'b1010, 16'h0, 4'b1000, 3};  // ptr -> 0
    tbl[7] = '{4'b1100, 16'h0, 4'b0100, 2};  // ptr -> 3
    tbl[8] = '{4'b0101, 16'h0, 4'b0001, 0};  // wraps, ptr -> 1
    for (int i = 0; i < 9; i++) tbl[i].data = 16'($urandom);

    rst_n   = 1'b0;
    req     = '0;
    last    = '0;
    op_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fu_in", fu_in, 0);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one full ownership per vector, last on the 3rd OWN cycle.
    for (int i = 0; i < 9; i++) begin
      req     = tbl[i].req;
      op_data = tbl[i].data;
      last    = '0;
      d       = tbl[i].data;
      sb.push_back('{tbl[i].exp_gnt, 4'(d >> (4 * tbl[i].exp_idx))});
      @(negedge clk);
      e = sb.pop_front();
      chk("tbl_gnt", gnt, e.gnt);
      chk("tbl_busy", busy, 1);
      chk("tbl_fu_in", fu_in, e.fu);
      chk("tbl_fu_valid", fu_valid, 1);
      @(negedge clk);
      @(negedge clk);
      chk("tbl_hold_gnt", gnt, e.gnt);
      last = e.gnt;
      @(negedge clk);
      chk("tbl_gap_gnt", gnt, 0);
      chk("tbl_gap_busy", busy, 0);
      chk("tbl_gap_fu_in", fu_in, 0);
      chk("tbl_gap_fu_valid", fu_valid, 0);
      chk("tbl_gap_timeout", timeout, 0);
      req  = '0;
      last = '0;
      @(negedge clk);
    end

    // Operand routing: owner 1 carries 4'hA, everyone else 4'h5.
    req     = 4'b0010;
    op_data = 16'h55A5;
    @(negedge clk);
    chk("mux_gnt", gnt, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      chk("mux_fu_in", fu_in, 4'hA);
      chk("mux_fu_valid", fu_valid, 1);
      if (c == 2) last = 4'b0010;
      @(negedge clk);
    end
    chk("mux_gap_fu_in", fu_in, 0);
    chk("mux_gap_fu_valid", fu_valid, 0);
    chk("mux_gap_gnt", gnt, 0);
    req  = '0;
    last = '0;
    @(negedge clk);

    // Forced release: owner 2 holds forever, 16 owned cycles then timeout.
    req = 4'b0100;
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 40 && gnt == 4'b0100; c++) begin
      n++;
      @(negedge clk);
    end
    chk("to_hold_cycles", n, 16);
    chk("to_pulse", timeout, 1);
    chk("to_gap_gnt", gnt, 0);
    @(negedge clk);
    chk("to_pulse_width", timeout, 0);
    chk("to_idle_gnt", gnt, 0);
    @(negedge clk);
    chk("to_regrant", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("drop_no_timeout", timeout, 0);
    chk("drop_gap_gnt", gnt, 0);
    @(negedge clk);

    // last coincides with expiry: normal release, ptr still advances.
    req = 4'b0001;
    @(negedge clk);
    chk("co_gnt", gnt, 4'b0001);
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      chk("co_hold", gnt, 4'b0001);
    end
    last = 4'b0001;
    @(negedge clk);
    chk("co_timeout", timeout, 0);
    chk("co_gap_gnt", gnt, 0);
    req  = 4'b0011;
    last = '0;
    @(negedge clk);
    chk("co_idle_gnt", gnt, 0);
    @(negedge clk);
    chk("co_ptr_adv", gnt, 4'b0010);
    last = 4'b0010;
    @(negedge clk);
    req  = '0;
    last = '0;
    @(negedge clk);

    // Asynchronous reset in the middle of an ownership.
    req = 4'b0100;
    @(negedge clk);
    chk("ar_gnt", gnt, 4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt_drop", gnt, 0);
    chk("ar_busy_drop", busy, 0);
    chk("ar_fu_valid_drop", fu_valid, 0);
    chk("ar_fu_in_drop", fu_in, 0);
    chk("ar_timeout", timeout, 0);
    req = 4'b1111;
    @(negedge clk);
    chk("ar_held_gnt", gnt, 0);
    chk("ar_held_timeout", timeout, 0);
    #2 rst_n = 1'b1;

    // All four requesting: order 0,1,2,3,0 from ptr=0, last after 2 owned
    // cycles. Between grants gnt is low for the GAP cycle plus the IDLE
    // arbitration cycle.
    for (int k = 0; k < 5; k++) sb.push_back('{4'(1 << (k % 4)), 4'h0});
    prev   = '0;
    owned  = 0;
    zeros  = 0;
    grants = 0;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        if (prev == 0) begin
          e = sb.pop_front();
          chk("rr_order", gnt, e.gnt);
          if (grants > 0) chk("rr_gap_cycles", zeros, 2);
          grants++;
          owned = 0;
        end else begin
          chk("rr_stable", gnt, prev);
        end
        owned++;
        if (owned == 2) last = gnt;
      end else begin
        if (prev != 0) zeros = 0;
        zeros++;
        last = '0;
      end
      prev = gnt;
    end
    chk("rr_all_grants", sb.size(), 0);
    req  = '0;
    last = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("end_idle_gnt", gnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
